// File: rtl/credit_rr_arb.sv
// ============================================================================
// credit_rr_arb : round-robin arbiter sharing one credit-flow-controlled link
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_rr_arb #(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = 8,
  parameter  int MAX_CREDITS = 4,
  localparam int CNT_W       = $clog2(MAX_CREDITS + 1),
  localparam int SRC_W       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_vld,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_rdy,
  output logic                    o_vld,
  output logic [DATA_W-1:0]       o_data,
  output logic [SRC_W-1:0]        o_src,
  input  logic                    i_credit_ret,
  output logic [CNT_W-1:0]        o_credits,
  output logic                    o_err
);

  localparam logic [CNT_W-1:0] C_MAX_CREDITS = CNT_W'(MAX_CREDITS);

  logic [SRC_W-1:0]  ptr_q,     ptr_d;
  logic [CNT_W-1:0]  credits_q, credits_d;
  logic              vld_q,     vld_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [SRC_W-1:0]  src_q,     src_d;
  logic              err_q,     err_d;

  logic              w_gnt;
  logic [SRC_W-1:0]  w_win;
  logic [DATA_W-1:0] w_win_data;

  // Scan from farthest to nearest so the first requester after ptr wins last.
  always_comb begin
    int idx;
    w_gnt = 1'b0;
    w_win = '0;
    idx   = 0;
    if ((credits_q != '0) && !rst) begin
      for (int off = N_REQ; off >= 1; off--) begin
        idx = (int'(ptr_q) + off) % N_REQ;
        if (i_vld[idx]) begin
          w_gnt = 1'b1;
          w_win = idx[SRC_W-1:0];
        end
      end
    end
  end

  assign w_win_data = i_data[int'(w_win)*DATA_W +: DATA_W];
  assign o_rdy      = w_gnt ? (N_REQ'(1) << w_win) : '0;

  always_comb begin
    ptr_d     = ptr_q;
    credits_d = credits_q;
    vld_d     = w_gnt;
    data_d    = data_q;
    src_d     = src_q;
    err_d     = err_q;

    if (w_gnt) begin
      ptr_d  = w_win;
      data_d = w_win_data;
      src_d  = w_win;
    end

    if (w_gnt && !i_credit_ret) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (!w_gnt && i_credit_ret) begin
      // A return with no free-able slot means downstream miscounted.
      if (credits_q == C_MAX_CREDITS) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= SRC_W'(N_REQ - 1);
      credits_q <= C_MAX_CREDITS;
      vld_q     <= 1'b0;
      data_q    <= '0;
      src_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      src_q     <= src_d;
      err_q     <= err_d;
    end
  end

  assign o_vld     = vld_q;
  assign o_data    = data_q;
  assign o_src     = src_q;
  assign o_credits = credits_q;
  assign o_err     = err_q;

endmodule

`default_nettype wire
